cpc_rom_loader: RTL
===================

# cpc_rom_loader

Buffers the HPS ROM download stream (ioctl index 0) and turns it into SDRAM boot writes for the Amstrad core. It sits between `hps_io` and the SDRAM controller's boot port, which is muxed in while the core is held in reset. It maps 16 KB download pages onto the CPC ROM layout and paces writes to the SDRAM refresh/slot strobe `ce_ref`. A small FIFO means the HPS is stalled only when the SDRAM side falls behind.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `clk_sys` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `ce_ref` in 1: SDRAM slot strobe; one-cycle pulse every 16 `clk_sys`.
- `ioctl_download` in 1: download in progress.
- `ioctl_index` in 8: download target; only 0 is handled.
- `ioctl_wr` in 1: byte strobe; one cycle per byte.
- `ioctl_addr` in 25: byte offset in the file.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: stall request to HPS.
- `rom_download` out 1: `ioctl_download & (ioctl_index==0)`, combinational; used to hold the core in reset.
- `boot_wr` out 1: SDRAM write request.
- `boot_a` out 23: SDRAM byte address.
- `boot_bank` out 2: SDRAM bank.
- `boot_dout` out 8: write data.
- `load_done` out 1: one-cycle pulse when a ROM download has fully reached SDRAM.
- `overflow` out 1: sticky; a byte was lost. Cleared by reset or by the start of the next download.

## Operation
- **Reset** (`reset_n`=0 at a clock edge):
  - FIFO emptied; state IDLE.
  - `boot_wr`, `load_done`, `overflow` = 0; `boot_a`, `boot_bank`, `boot_dout` = 0.
  - `ioctl_wait` = 0 because count is 0.
  - Any write in flight is abandoned.
- **Accept**: when `rom_download & ioctl_wr` is high, decode page p = `ioctl_addr[24:14]`.
  - p = 0 or 3: upper address 9'h000.
  - p = 1 or 4: upper address 9'h100.
  - p = 2 or 5: upper address 9'h107.
  - Bank is 0 for p = 0..2 and 1 for p = 3..5.
  - `boot_a[13:0]` = `ioctl_addr[13:0]`.
  - p ≥ 6: byte discarded silently. Not pushed, not counted as overflow.
  - Valid bytes push {bank, addr, data} into the FIFO.
- **Full**: a valid byte arriving while count = DEPTH is dropped and sets `overflow`. Under correct HPS behaviour this never happens.
- **`ioctl_wait`** = (count ≥ DEPTH−1), driven combinationally from the registered count. This leaves one entry of slack for a write that lands in the same cycle `ioctl_wait` rises.
- **Drain FSM** (state advances only on `ce_ref` cycles):
  - IDLE: if FIFO is non-empty, latch the head into `boot_a`, `boot_bank`, `boot_dout`; set `boot_wr`=1; go to WRITE.
  - WRITE: `boot_wr`=0; pop head; go to IDLE. Each byte therefore holds `boot_wr` for exactly one full `ce_ref` period, and throughput is one byte per two `ce_ref` periods.
- **Completion**: a ROM download is *armed* on the rising edge of `rom_download`. Arming clears `overflow`.
  - Once armed, and after `rom_download` has fallen, the first cycle with FIFO empty and state IDLE pulses `load_done` and disarms.
  - Falling while bytes are still buffered does not cut the drain short.
- **Non-zero `ioctl_index`**: bytes ignored; no effect on FIFO, `ioctl_wait`, or flags.
- **Simultaneous push and pop** in one cycle: count unchanged, data ordering preserved.
- **Count width**: clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Timing
- Push at edge t: count and `ioctl_wait` update at t+1.
- Push-to-`boot_wr`:
  - Minimum 1 cycle, when the next `ce_ref` falls at t+1 and the FSM is IDLE.
  - Maximum 16 cycles plus 32 per queued entry ahead.
- `boot_wr` high for exactly 16 `clk_sys` cycles, from one `ce_ref` edge to the next. `boot_a`, `boot_bank`, `boot_dout` stable throughout and held after.
- Pop occurs on the `ce_ref` that drops `boot_wr`. `ioctl_wait` can fall in the following cycle.
- `load_done`: exactly one cycle wide, registered.
- `rom_download` combinational, no latency.

## Test plan
- **Reset**: drive `reset_n`=0 for 3 cycles mid-WRITE with 3 bytes queued.
  - Next cycle: `boot_wr`=0, `ioctl_wait`=0, FIFO empty.
  - No further `boot_wr` until new data arrives.
- **Mapping**: write bytes AA@0x00000, BB@0x04005, CC@0x0BFFF, DD@0x0C001.
  - SDRAM writes, in order: (a=0x000000, bank 0, AA), (0x400005, 0, BB), (0x41FFFF, 0, CC), (0x000001, 1, DD).
  - Byte at 0x18000 produces no write and does not set `overflow`.
- **Back-pressure**: HPS writes every cycle while `ioctl_wait`=0, 64 bytes, DEPTH=4.
  - Count never exceeds 4; `overflow` stays 0.
  - All 64 bytes reach SDRAM in order, each `boot_wr` pulse 16 cycles long.
- **Forced overflow**: ignore `ioctl_wait` and push 6 bytes in 6 cycles.
  - `overflow`=1; exactly 4 or 5 bytes written, per drain timing; first 4 bytes intact.
  - Next download start clears `overflow`.
- **Completion**: drop `ioctl_download` with 3 bytes queued.
  - `load_done` pulses once, after the third `boot_wr` deasserts.
  - No pulse for an `ioctl_index`=1 download.
- **Simultaneous push and pop**: push exactly on the `ce_ref` that pops.
  - Count unchanged; data order correct.

Source files
------------

// File: rtl/cpc_rom_loader_if.sv
`default_nettype none
// ============================================================================
//  cpc_rom_loader_if
//  Bundle of the HPS download stream, the SDRAM boot write port and the
//  loader status flags, as seen between hps_io/SDRAM and cpc_rom_loader.
//  Revision: 1.0 - initial release
// ============================================================================
interface cpc_rom_loader_if;
  logic        ce_ref;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_download;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [1:0]  boot_bank;
  logic [7:0]  boot_dout;
  logic        load_done;
  logic        overflow;

  // System side: HPS stream source, SDRAM slot strobe, boot port sink.
  modport master (
    output ce_ref, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, rom_download, boot_wr, boot_a, boot_bank, boot_dout,
    input  load_done, overflow
  );

  // Loader side.
  modport slave (
    input  ce_ref, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, rom_download, boot_wr, boot_a, boot_bank, boot_dout,
    output load_done, overflow
  );
endinterface
`default_nettype wire

// File: rtl/cpc_rom_loader.sv
`default_nettype none
// ============================================================================
//  cpc_rom_loader
//  Buffers the HPS ROM download (index 0), maps 16 KB pages onto the CPC ROM
//  layout in SDRAM and issues one boot write per two ce_ref periods.
//  Revision: 1.0 - initial release
// ============================================================================
module cpc_rom_loader #(
  parameter int DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  cpc_rom_loader_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  // FIFO entry layout: {bank[1:0], sdram_addr[22:0], data[7:0]}
  logic [32:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [22:0]   r_boot_a;
  logic [1:0]    r_boot_bank;
  logic [7:0]    r_boot_dout;

  logic          r_dl_prev;
  logic          r_armed;
  logic          r_load_done;
  logic          r_overflow;

  logic          w_rom_download;
  logic [10:0]   w_page;
  logic          w_page_ok;
  logic [8:0]    w_upper;
  logic [1:0]    w_bank;
  logic          w_push_req;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_start;
  logic          w_rise;
  logic          w_done;
  logic [32:0]   w_head;

  assign w_rom_download = bus.ioctl_download & (bus.ioctl_index == 8'd0);
  assign w_page         = bus.ioctl_addr[24:14];

  // Page decode: pages 0..2 go to bank 0, 3..5 repeat the same layout in bank 1.
  always_comb begin
    w_upper   = 9'h000;
    w_bank    = 2'd0;
    w_page_ok = 1'b1;
    case (w_page)
      11'd0: begin w_upper = 9'h000; w_bank = 2'd0; end
      11'd1: begin w_upper = 9'h100; w_bank = 2'd0; end
      11'd2: begin w_upper = 9'h107; w_bank = 2'd0; end
      11'd3: begin w_upper = 9'h000; w_bank = 2'd1; end
      11'd4: begin w_upper = 9'h100; w_bank = 2'd1; end
      11'd5: begin w_upper = 9'h107; w_bank = 2'd1; end
      default: w_page_ok = 1'b0;
    endcase
  end

  assign w_push_req = w_rom_download & bus.ioctl_wr & w_page_ok;
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  // A byte arriving while full is lost even if a pop happens in the same cycle.
  assign w_push     = w_push_req & ~w_full;
  assign w_drop     = w_push_req &  w_full;
  assign w_pop      = bus.ce_ref & (r_state == S_WRITE);
  assign w_start    = bus.ce_ref & (r_state == S_IDLE) & ~w_empty;
  assign w_head     = r_mem[r_rd_ptr];

  assign w_rise     = w_rom_download & ~r_dl_prev;
  assign w_done     = r_armed & ~w_rom_download & w_empty & (r_state == S_IDLE);

  // FIFO storage; contents need no reset since count gates all reads.
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_bank, w_upper, bus.ioctl_addr[13:0], bus.ioctl_dout};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Drain FSM next state: one full ce_ref period in WRITE per byte.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)     w_state_nxt = S_WRITE;
      S_WRITE: if (bus.ce_ref)  w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Boot port address/data, captured from the FIFO head when a write starts.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_boot_a    <= '0;
      r_boot_bank <= '0;
      r_boot_dout <= '0;
    end else if (w_start) begin
      r_boot_bank <= w_head[32:31];
      r_boot_a    <= w_head[30:8];
      r_boot_dout <= w_head[7:0];
    end
  end

  // Download completion tracking and sticky overflow; a loss wins over a clear.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_dl_prev   <= 1'b0;
      r_armed     <= 1'b0;
      r_load_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_dl_prev   <= w_rom_download;
      r_load_done <= w_done;
      if (w_rise)      r_armed <= 1'b1;
      else if (w_done) r_armed <= 1'b0;
      if (w_drop)      r_overflow <= 1'b1;
      else if (w_rise) r_overflow <= 1'b0;
    end
  end

  assign bus.rom_download = w_rom_download;
  assign bus.ioctl_wait   = (r_count >= CW'(DEPTH - 1));
  assign bus.boot_wr      = (r_state == S_WRITE);
  assign bus.boot_a       = r_boot_a;
  assign bus.boot_bank    = r_boot_bank;
  assign bus.boot_dout    = r_boot_dout;
  assign bus.load_done    = r_load_done;
  assign bus.overflow     = r_overflow;

endmodule
`default_nettype wire
